// File: rtl/chess_mem_pkg.sv
// Shared definitions for the chess data-memory port-B logic.
//   CM_BOARD_BASE : default word address of board square 0
//   CM_FLAG_ADDR  : default word address of the "new move" flag
//   FLAG_VALUE    : value written to the flag word when a move completes
//   EMPTY_SQUARE  : value written to a vacated source square
//   arb_state_t   : command sequencer states
package chess_mem_pkg;

    localparam int CM_BOARD_BASE = 0;
    localparam int CM_FLAG_ADDR  = 36;
    localparam int FLAG_VALUE    = 1;
    localparam int EMPTY_SQUARE  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DST  = 2'd1,
        ST_WR_SRC  = 2'd2,
        ST_WR_FLAG = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_b_arbiter_if.sv
// Port-B bundle between the arbiter, the VGA renderer, the move-entry
// path and the dual-port memory.
//   vga_req/vga_addr        : renderer read request and address
//   vga_data/vga_valid      : registered read return to the renderer
//   cmd_valid/cmd_ready     : move command handshake
//   cmd_src/cmd_dst         : squares 0..63
//   cmd_piece               : piece code written to the destination square
//   busy                    : a move is being written
//   mem_addr/mem_wdata/mem_we/mem_q : dmem port B
// Modport slave is the arbiter; master is everything around it.
interface dmem_b_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [5:0]        cmd_src;
    logic [5:0]        cmd_dst;
    logic [DATA_W-1:0] cmd_piece;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  vga_req, vga_addr,
        input  cmd_valid, cmd_src, cmd_dst, cmd_piece,
        input  mem_q,
        output vga_data, vga_valid,
        output cmd_ready, busy,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output vga_req, vga_addr,
        output cmd_valid, cmd_src, cmd_dst, cmd_piece,
        output mem_q,
        input  vga_data, vga_valid,
        input  cmd_ready, busy,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/starve_counter.sv
// Counts consecutive cycles a pending write has been deferred by VGA reads.
//   clock, reset : rising-edge clock, async active-high reset
//   clear        : return count to zero (write issued or sequencer idle)
//   inc          : one more deferred cycle
//   at_limit     : count has reached MAX_WAIT-1; the next write must go
// The count saturates at MAX_WAIT-1 so it can never exceed the limit even
// if clear is late.
module starve_counter #(
    parameter int MAX_WAIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT);

endmodule

// File: rtl/dmem_b_arbiter.sv
// Owns dmem port B. The VGA renderer reads through it continuously; one
// accepted move becomes three ordered writes (destination square, source
// square, notify flag). Each write takes a cycle in which VGA is not
// reading, or steals one once it has waited MAX_WAIT cycles.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : dmem_b_arbiter_if.slave (VGA, command and memory signals)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no move pending, command accepted here
// ST_WR_DST  | writing piece code to the destination square
// ST_WR_SRC  | clearing the source square
// ST_WR_FLAG | writing FLAG_VALUE to the processor's flag word
module dmem_b_arbiter
    import chess_mem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int BOARD_BASE = CM_BOARD_BASE,
    parameter int FLAG_ADDR  = CM_FLAG_ADDR,
    parameter int MAX_WAIT   = 64
) (
    input logic            clock,
    input logic            reset,
    dmem_b_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BOARD_BASE);
    localparam logic [ADDR_W-1:0] FLAG_A  = ADDR_W'(FLAG_ADDR);
    localparam logic [DATA_W-1:0] FLAG_D  = DATA_W'(FLAG_VALUE);
    localparam logic [DATA_W-1:0] EMPTY_D = DATA_W'(EMPTY_SQUARE);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic [5:0]        src_q;
    logic [5:0]        dst_q;
    logic [DATA_W-1:0] piece_q;

    logic              in_write;
    logic              at_limit;
    logic              slot;
    logic              accept;
    logic              cnt_clear;
    logic              cnt_inc;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    logic              rd_granted;
    logic              rd_p1;
    logic              vga_valid_q;
    logic [DATA_W-1:0] vga_data_q;

    assign in_write = (state != ST_IDLE);

    // A write goes whenever VGA is quiet; under continuous VGA traffic it
    // goes anyway on the last allowed waiting cycle.
    assign slot = in_write && (!bus.vga_req || at_limit);

    assign cnt_clear = !in_write || slot;
    assign cnt_inc   = in_write && !slot;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = bus.vga_addr;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WR_DST;
                end
            end
            ST_WR_DST: begin
                if (slot) begin
                    mem_we    = 1'b1;
                    mem_addr  = BASE_A + ADDR_W'(dst_q);
                    mem_wdata = piece_q;
                    // A null move leaves the piece in place; clearing the
                    // source would erase what was just written.
                    state_nxt = (src_q == dst_q) ? ST_WR_FLAG : ST_WR_SRC;
                end
            end
            ST_WR_SRC: begin
                if (slot) begin
                    mem_we    = 1'b1;
                    mem_addr  = BASE_A + ADDR_W'(src_q);
                    mem_wdata = EMPTY_D;
                    state_nxt = ST_WR_FLAG;
                end
            end
            ST_WR_FLAG: begin
                if (slot) begin
                    mem_we    = 1'b1;
                    mem_addr  = FLAG_A;
                    mem_wdata = FLAG_D;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            piece_q <= '0;
        end else if (accept) begin
            src_q   <= bus.cmd_src;
            dst_q   <= bus.cmd_dst;
            piece_q <= bus.cmd_piece;
        end
    end

    // Read return: address in N, mem_q in N+1, registered to VGA in N+2.
    // A stolen cycle is not a granted read, so nothing comes back for it
    // and vga_data keeps its previous value.
    assign rd_granted = bus.vga_req && !mem_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_p1       <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
        end else begin
            rd_p1       <= rd_granted;
            vga_valid_q <= rd_p1;
            if (rd_p1) begin
                vga_data_q <= bus.mem_q;
            end
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.cmd_ready = !in_write;
    assign bus.busy      = in_write;
    assign bus.vga_valid = vga_valid_q;
    assign bus.vga_data  = vga_data_q;

endmodule

// File: tb/tb_dmem_b_arbiter.sv
module tb_dmem_b_arbiter;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int BOARD_BASE = 0;
    localparam int FLAG_ADDR  = 36;
    localparam int MAX_WAIT   = 4;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } wlog_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_b_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_b_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BOARD_BASE (BOARD_BASE),
        .FLAG_ADDR  (FLAG_ADDR),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory fixture standing in for dmem port B (registered read).
    logic [31:0] fix_mem [0:4095];
    always @(posedge clock) begin
        logic [31:0] rd;
        rd = fix_mem[bus.mem_addr];
        bus.mem_q <= rd;
        if (bus.mem_we) fix_mem[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:4095];
    wr_t         wq[$];
    int          waited = 0;
    bit          p0_v = 0, p1_v = 0;
    logic [31:0] p0_d = '0, p1_d = '0;
    logic [31:0] exp_vdata = '0;
    bit          last_accept = 0;

    wlog_t       wlog[$];
    bit          rdy_hist[int];
    bit          vv_hist[int];
    logic [31:0] vd_hist[int];

    function automatic logic [11:0] sq_addr(input logic [5:0] sq);
        return 12'(BOARD_BASE + int'(sq));
    endfunction

    always @(negedge clock) begin
        bit          busy_m;
        bit          slot;
        logic [11:0] exp_addr;
        rdy_hist[cyc] = bus.cmd_ready;
        vv_hist[cyc]  = bus.vga_valid;
        vd_hist[cyc]  = bus.vga_data;
        last_accept   = bus.cmd_valid && bus.cmd_ready;
        if (bus.mem_we) wlog.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
        if (reset) begin
            check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
            check("rst_busy",      64'(bus.busy),      64'd0);
            check("rst_mem_we",    64'(bus.mem_we),    64'd0);
            check("rst_vga_valid", 64'(bus.vga_valid), 64'd0);
            check("rst_vga_data",  64'(bus.vga_data),  64'd0);
            wq.delete();
            waited    = 0;
            p0_v      = 0;
            p1_v      = 0;
            exp_vdata = '0;
        end else begin
            busy_m   = (wq.size() != 0);
            slot     = busy_m && (!bus.vga_req || waited == MAX_WAIT - 1);
            exp_addr = slot ? wq[0].addr : bus.vga_addr;
            if (p1_v) exp_vdata = p1_d;
            check("cmd_ready", 64'(bus.cmd_ready), 64'(!busy_m));
            check("busy",      64'(bus.busy),      64'(busy_m));
            check("mem_we",    64'(bus.mem_we),    64'(slot));
            check("mem_addr",  64'(bus.mem_addr),  64'(exp_addr));
            if (slot) check("mem_wdata", 64'(bus.mem_wdata), 64'(wq[0].data));
            check("vga_valid", 64'(bus.vga_valid), 64'(p1_v));
            check("vga_data",  64'(bus.vga_data),  64'(exp_vdata));
            if (slot) begin
                ref_mem[wq[0].addr] = wq[0].data;
                void'(wq.pop_front());
                waited = 0;
            end else if (busy_m) begin
                waited++;
            end
            p1_v = p0_v;
            p1_d = p0_d;
            p0_v = bus.vga_req && !slot;
            p0_d = ref_mem[bus.vga_addr];
            if (!busy_m && bus.cmd_valid) begin
                wq.push_back('{sq_addr(bus.cmd_dst), bus.cmd_piece});
                if (bus.cmd_src != bus.cmd_dst) wq.push_back('{sq_addr(bus.cmd_src), 32'd0});
                wq.push_back('{12'(FLAG_ADDR), 32'd1});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input int src, input int dst, input logic [31:0] piece, output int acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = 6'(src);
        bus.cmd_dst   = 6'(dst);
        bus.cmd_piece = piece;
        acc = cyc;
    endtask

    initial begin
        int acc;
        int n;
        int wbase;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_piece = '0;
        for (int i = 0; i < 4096; i++) begin
            fix_mem[i] = 32'h1000 + 32'(i * 3);
            ref_mem[i] = 32'h1000 + 32'(i * 3);
        end

        @(negedge clock);
        check("lit_rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("lit_rst_we",    64'(bus.mem_we),    64'd0);
        check("lit_rst_vdata", 64'(bus.vga_data),  64'd0);
        repeat (2) step();
        reset = 1'b0;
        step();

        // A: unobstructed move, three back-to-back writes
        send_cmd(12, 28, 32'h49, acc);
        wlog.delete();
        step();
        bus.cmd_valid = 1'b0;
        repeat (5) step();
        check("A_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            check("A_w0_addr", 64'(wlog[0].addr), 64'd28);
            check("A_w0_data", 64'(wlog[0].data), 64'h49);
            check("A_w0_cyc",  64'(wlog[0].cyc),  64'(acc + 1));
            check("A_w1_addr", 64'(wlog[1].addr), 64'd12);
            check("A_w1_data", 64'(wlog[1].data), 64'd0);
            check("A_w1_cyc",  64'(wlog[1].cyc),  64'(acc + 2));
            check("A_w2_addr", 64'(wlog[2].addr), 64'd36);
            check("A_w2_data", 64'(wlog[2].data), 64'd1);
            check("A_w2_cyc",  64'(wlog[2].cyc),  64'(acc + 3));
        end
        check("A_busy_n3",  64'(rdy_hist[acc + 3]), 64'd0);
        check("A_ready_n4", 64'(rdy_hist[acc + 4]), 64'd1);

        // B: VGA reads continuously; each write steals the 4th waiting cycle
        bus.vga_req  = 1'b1;
        bus.vga_addr = 12'd20;
        send_cmd(12, 28, 32'h49, acc);
        wlog.delete();
        step();
        bus.cmd_valid = 1'b0;
        repeat (15) step();
        bus.vga_req = 1'b0;
        check("B_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            check("B_w0_cyc", 64'(wlog[0].cyc), 64'(acc + 4));
            check("B_w1_cyc", 64'(wlog[1].cyc), 64'(acc + 8));
            check("B_w2_cyc", 64'(wlog[2].cyc), 64'(acc + 12));
        end
        check("B_valid_granted", 64'(vv_hist[acc + 5]),  64'd1);
        check("B_nvalid_st0",    64'(vv_hist[acc + 6]),  64'd0);
        check("B_nvalid_st1",    64'(vv_hist[acc + 10]), 64'd0);
        check("B_nvalid_st2",    64'(vv_hist[acc + 14]), 64'd0);
        check("B_ready_back",    64'(rdy_hist[acc + 13]), 64'd1);
        step();

        // C: null move writes destination and flag only
        send_cmd(5, 5, 32'h21, acc);
        wlog.delete();
        step();
        bus.cmd_valid = 1'b0;
        repeat (4) step();
        check("C_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check("C_w0_addr", 64'(wlog[0].addr), 64'd5);
            check("C_w0_data", 64'(wlog[0].data), 64'h21);
            check("C_w1_addr", 64'(wlog[1].addr), 64'd36);
            check("C_w1_cyc",  64'(wlog[1].cyc),  64'(acc + 2));
        end
        check("C_ready", 64'(rdy_hist[acc + 3]), 64'd1);

        // D: read latency, square 7 holding 0xABCD
        send_cmd(8, 7, 32'hABCD, acc);
        step();
        bus.cmd_valid = 1'b0;
        repeat (4) step();
        bus.vga_req  = 1'b1;
        bus.vga_addr = 12'd7;
        n = cyc;
        step();
        bus.vga_req = 1'b0;
        repeat (3) step();
        check("D_valid_n1", 64'(vv_hist[n + 1]), 64'd0);
        check("D_valid_n2", 64'(vv_hist[n + 2]), 64'd1);
        check("D_data_n2",  64'(vd_hist[n + 2]), 64'hABCD);
        check("D_valid_n3", 64'(vv_hist[n + 3]), 64'd0);

        // E: second command held while busy, taken on first idle cycle
        send_cmd(1, 2, 32'h11, acc);
        wlog.delete();
        step();
        bus.cmd_src   = 6'd40;
        bus.cmd_dst   = 6'd50;
        bus.cmd_piece = 32'h77;
        repeat (4) step();
        bus.cmd_valid = 1'b0;
        repeat (5) step();
        check("E_ready_n4", 64'(rdy_hist[acc + 4]), 64'd1);
        check("E_nwrites",  64'(wlog.size()), 64'd6);
        if (wlog.size() == 6) begin
            check("E_w3_addr", 64'(wlog[3].addr), 64'd50);
            check("E_w3_data", 64'(wlog[3].data), 64'h77);
            check("E_w3_cyc",  64'(wlog[3].cyc),  64'(acc + 5));
        end

        // F: reset after the first write abandons the sequence
        fix_mem[FLAG_ADDR] = 32'h5A;
        ref_mem[FLAG_ADDR] = 32'h5A;
        send_cmd(30, 31, 32'h66, acc);
        wlog.delete();
        step();
        bus.cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("F_rst_busy",  64'(bus.busy),      64'd0);
        check("F_rst_we",    64'(bus.mem_we),    64'd0);
        check("F_rst_ready", 64'(bus.cmd_ready), 64'd1);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("F_nwrites", 64'(wlog.size()), 64'd1);
        check("F_dst",     64'(fix_mem[31]), 64'h66);
        check("F_src",     64'(fix_mem[30]), 64'(32'h1000 + 32'(30 * 3)));
        check("F_flag",    64'(fix_mem[FLAG_ADDR]), 64'h5A);

        // Random traffic against the model
        wbase = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
            end
            bus.vga_req  = ($urandom_range(0, 99) < 70);
            bus.vga_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                                       : 12'($urandom_range(0, 63));
            if (!bus.cmd_valid || last_accept) begin
                bus.cmd_valid = ($urandom_range(0, 99) < 30);
                bus.cmd_src   = 6'($urandom_range(0, 63));
                bus.cmd_dst   = ($urandom_range(0, 3) == 0) ? bus.cmd_src
                                                            : 6'($urandom_range(0, 63));
                bus.cmd_piece = $urandom;
            end
            wbase++;
        end
        bus.cmd_valid = 1'b0;
        bus.vga_req   = 1'b0;
        repeat (20) step();
        check("R_cycles_run", 64'(wbase), 64'd3000);
        check("R_drained",    64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
